// File: rtl/mux_arbiter.sv
// mux_arbiter: two-requester arbiter that shares one WIDTH-bit select mux and
// feeds a single-entry registered output stage with a valid/ready handshake.
// Each grant lasts at most MAX_BURST accepted beats. When the burst limit is
// reached, or the owner stops asking, the grant moves straight to the other
// requester if it is asking, so there is no idle cycle between owners.
// Configuration: define MUX_ARB_FIXED_PRIO_EN to let requester 1 win every tie.
// When it is undefined (the default build), ties alternate round-robin.
module mux_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] input_1,
    input  logic             valid_1,
    output logic             ready_1,
    input  logic [WIDTH-1:0] input_2,
    input  logic             valid_2,
    output logic             ready_2,
    output logic             sel,
    output logic [WIDTH-1:0] output_1,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int               CNT_W     = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_1 = 2'd1,
        GRANT_2 = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    state_t           w_other_state;
    logic [CNT_W-1:0] r_beat_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;

    logic             w_grant_1;
    logic             w_grant_2;
    logic             w_pipe_ok;
    logic             w_accept;
    logic             w_cur_valid;
    logic             w_other_valid;
    logic             w_burst_end;
    logic             w_release;
    logic             w_tie_to_2;
    logic             w_keep_first;
    logic [WIDTH-1:0] w_mux_data;

    assign w_grant_1     = (r_state == GRANT_1);
    assign w_grant_2     = (r_state == GRANT_2);
    assign w_pipe_ok     = !r_out_valid || out_ready;
    assign w_cur_valid   = w_grant_2 ? valid_2 : valid_1;
    assign w_other_valid = w_grant_2 ? valid_1 : valid_2;
    assign w_other_state = w_grant_2 ? GRANT_1 : GRANT_2;
    assign w_accept      = (w_grant_1 || w_grant_2) && w_pipe_ok && w_cur_valid;
    assign w_burst_end   = w_accept && (r_beat_cnt == LAST_BEAT);
    assign w_release     = w_burst_end || ((w_grant_1 || w_grant_2) && !w_cur_valid);
    assign w_mux_data    = sel ? input_2 : input_1;

    assign sel       = w_grant_2;
    assign ready_1   = w_grant_1 && w_pipe_ok;
    assign ready_2   = w_grant_2 && w_pipe_ok;
    assign output_1  = r_out_data;
    assign out_valid = r_out_valid;

`ifdef MUX_ARB_FIXED_PRIO_EN
    // Requester 1 wins every tie, so history is not needed. A requester 1
    // whose burst just ran out keeps the grant as long as it is still asking.
    assign w_tie_to_2   = 1'b0;
    assign w_keep_first = w_grant_1;
`else
    logic r_last;

    // Remember who was released most recently (1 = requester 2). Coming out
    // of reset this reads as requester 2, so requester 1 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_release) begin
            r_last <= w_grant_2;
        end
    end

    assign w_tie_to_2   = !r_last;
    assign w_keep_first = 1'b0;
`endif

    // Arbitration state and per-grant beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_beat_cnt <= w_next_cnt;
        end
    end

    // Grant selection. A release hands the grant straight to the other
    // requester when it is waiting; otherwise the current owner is granted
    // again only if the release was due to the burst limit.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_beat_cnt;
        unique case (r_state)
            IDLE: begin
                if (valid_1 && valid_2) begin
                    w_next_state = w_tie_to_2 ? GRANT_2 : GRANT_1;
                end else if (valid_1) begin
                    w_next_state = GRANT_1;
                end else if (valid_2) begin
                    w_next_state = GRANT_2;
                end
            end
            GRANT_1, GRANT_2: begin
                if (w_release) begin
                    w_next_cnt = '0;
                    if (w_keep_first && w_burst_end) begin
                        w_next_state = r_state;
                    end else if (w_other_valid) begin
                        w_next_state = w_other_state;
                    end else if (w_burst_end) begin
                        w_next_state = r_state;
                    end else begin
                        w_next_state = IDLE;
                    end
                end else if (w_accept) begin
                    w_next_cnt = r_beat_cnt + 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Single-entry output stage. A new beat overwrites the word being
    // drained in the same cycle; the word is otherwise held until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_data  <= w_mux_data;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule
